// File: rtl/shader_dispatch_ctrl.sv
// shader_dispatch_ctrl: streams preloaded uniforms and instructions into a shader core, buffers its results.
// Optional DRAIN watchdog is compiled in when SHDISP_TIMEOUT_EN is defined.
module shader_dispatch_ctrl #(
  parameter int PROG_DEPTH     = 256,
  parameter int UNIF_DEPTH     = 16,
  parameter int RES_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int PA = $clog2(PROG_DEPTH),
  localparam int UA = $clog2(UNIF_DEPTH),
  localparam int RA = $clog2(RES_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_prog_we,
  input  logic [PA-1:0] cfg_prog_addr,
  input  logic [31:0]   cfg_prog_wdata,
  input  logic          cfg_unif_we,
  input  logic [UA-1:0] cfg_unif_idx,
  input  logic [31:0]   cfg_unif_addr,
  input  logic [127:0]  cfg_unif_data,
  input  logic          start,
  input  logic [PA:0]   prog_len,
  input  logic [UA:0]   unif_cnt,
  input  logic [15:0]   exp_out_cnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sp_uniform_valid,
  output logic [31:0]   sp_uniform_addr,
  output logic [127:0]  sp_uniform_data,
  input  logic          sp_uniform_ready,
  output logic          sp_instr_valid,
  output logic [31:0]   sp_instr,
  input  logic          sp_instr_ready,
  input  logic          sp_out_valid,
  input  logic [127:0]  sp_out_data,
  output logic          sp_out_ready,
  output logic          res_valid,
  output logic [127:0]  res_data,
  input  logic          res_ready,
  output logic [RA:0]   res_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNIF,
    S_INSTR,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [PA:0] PROG_MAX = (PA+1)'(PROG_DEPTH);
  localparam logic [UA:0] UNIF_MAX = (UA+1)'(UNIF_DEPTH);
  localparam logic [RA:0] RES_FULL = (RA+1)'(RES_DEPTH);

  state_t state;

  logic [31:0]  prog_mem      [PROG_DEPTH];
  logic [31:0]  unif_addr_mem [UNIF_DEPTH];
  logic [127:0] unif_data_mem [UNIF_DEPTH];
  logic [127:0] res_mem       [RES_DEPTH];

  logic [PA:0]   prog_len_q;
  logic [PA:0]   instr_idx;
  logic [PA:0]   instr_nxt;
  logic [UA:0]   unif_cnt_q;
  logic [UA:0]   unif_idx;
  logic [UA:0]   unif_nxt;
  logic [15:0]   exp_cnt_q;
  logic [15:0]   rx_cnt;
  logic [RA-1:0] wr_ptr;
  logic [RA-1:0] rd_ptr;

  logic out_fire;
  logic in_job;
  logic push;
  logic pop;
  logic stray;
  logic bad_len;

`ifdef SHDISP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Results arriving outside a job are consumed but never stored.
  assign out_fire  = sp_out_valid & sp_out_ready;
  assign in_job    = (state == S_UNIF) || (state == S_INSTR) || (state == S_DRAIN);
  assign push      = out_fire & in_job;
  assign stray     = out_fire & ~in_job;
  assign pop       = res_valid & res_ready;
  assign instr_nxt = instr_idx + (PA+1)'(1);
  assign unif_nxt  = unif_idx + (UA+1)'(1);
  assign bad_len   = (prog_len > PROG_MAX) || (unif_cnt > UNIF_MAX);

  assign sp_out_ready = (res_count != RES_FULL);
  assign res_valid    = (res_count != '0);
  assign res_data     = res_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (cfg_prog_we && !busy) begin
      prog_mem[cfg_prog_addr] <= cfg_prog_wdata;
    end
    if (cfg_unif_we && !busy) begin
      unif_addr_mem[cfg_unif_idx] <= cfg_unif_addr;
      unif_data_mem[cfg_unif_idx] <= cfg_unif_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr] <= sp_out_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      res_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + RA'(1);
      if (pop)  rd_ptr <= rd_ptr + RA'(1);
      case ({push, pop})
        2'b10:   res_count <= res_count + (RA+1)'(1);
        2'b01:   res_count <= res_count - (RA+1)'(1);
        default: res_count <= res_count;
      endcase
    end
  end

  // Job sequencer; every stream output is registered so valid never depends on ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      sp_uniform_valid <= 1'b0;
      sp_uniform_addr  <= '0;
      sp_uniform_data  <= '0;
      sp_instr_valid   <= 1'b0;
      sp_instr         <= '0;
      prog_len_q       <= '0;
      unif_cnt_q       <= '0;
      exp_cnt_q        <= '0;
      instr_idx        <= '0;
      unif_idx         <= '0;
      rx_cnt           <= '0;
`ifdef SHDISP_TIMEOUT_EN
      wd_cnt           <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (push && rx_cnt != 16'hFFFF) rx_cnt <= rx_cnt + 16'd1;
      if (stray) err <= 1'b1;
`ifdef SHDISP_TIMEOUT_EN
      if (state != S_DRAIN) wd_cnt <= '0;
`endif

      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            rx_cnt     <= '0;
            prog_len_q <= prog_len;
            unif_cnt_q <= unif_cnt;
            exp_cnt_q  <= exp_out_cnt;
            err        <= stray;
            if (bad_len) begin
              err   <= 1'b1;
              state <= S_DONE;
              done  <= 1'b1;
            end else if (unif_cnt != '0) begin
              state            <= S_UNIF;
              unif_idx         <= '0;
              sp_uniform_valid <= 1'b1;
              sp_uniform_addr  <= unif_addr_mem[0];
              sp_uniform_data  <= unif_data_mem[0];
            end else if (prog_len != '0) begin
              state          <= S_INSTR;
              instr_idx      <= '0;
              sp_instr_valid <= 1'b1;
              sp_instr       <= prog_mem[0];
            end else if (exp_out_cnt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end

        S_UNIF: begin
          if (sp_uniform_ready) begin
            if (unif_nxt == unif_cnt_q) begin
              sp_uniform_valid <= 1'b0;
              if (prog_len_q != '0) begin
                state          <= S_INSTR;
                instr_idx      <= '0;
                sp_instr_valid <= 1'b1;
                sp_instr       <= prog_mem[0];
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              unif_idx        <= unif_nxt;
              sp_uniform_addr <= unif_addr_mem[unif_nxt[UA-1:0]];
              sp_uniform_data <= unif_data_mem[unif_nxt[UA-1:0]];
            end
          end
        end

        S_INSTR: begin
          if (sp_instr_ready) begin
            if (instr_nxt == prog_len_q) begin
              sp_instr_valid <= 1'b0;
              state          <= S_DRAIN;
            end else begin
              instr_idx <= instr_nxt;
              sp_instr  <= prog_mem[instr_nxt[PA-1:0]];
            end
          end
        end

        S_DRAIN: begin
          if (rx_cnt >= exp_cnt_q) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
`ifdef SHDISP_TIMEOUT_EN
          else if (push) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            err   <= 1'b1;
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shader_dispatch_ctrl.sv
// Scoreboard bench for shader_dispatch_ctrl: expected beats are queued at stimulus time, monitors pop and compare.
module tb_shader_dispatch_ctrl;

  localparam int PROG_DEPTH = 256;
  localparam int UNIF_DEPTH = 16;
  localparam int RES_DEPTH  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_prog_we;
  logic [7:0]   cfg_prog_addr;
  logic [31:0]  cfg_prog_wdata;
  logic         cfg_unif_we;
  logic [3:0]   cfg_unif_idx;
  logic [31:0]  cfg_unif_addr;
  logic [127:0] cfg_unif_data;
  logic         start;
  logic [8:0]   prog_len;
  logic [4:0]   unif_cnt;
  logic [15:0]  exp_out_cnt;
  logic         busy;
  logic         done;
  logic         err;
  logic         sp_uniform_valid;
  logic [31:0]  sp_uniform_addr;
  logic [127:0] sp_uniform_data;
  logic         sp_uniform_ready;
  logic         sp_instr_valid;
  logic [31:0]  sp_instr;
  logic         sp_instr_ready;
  logic         sp_out_valid;
  logic [127:0] sp_out_data;
  logic         sp_out_ready;
  logic         res_valid;
  logic [127:0] res_data;
  logic         res_ready;
  logic [3:0]   res_count;

  always #5 clk = ~clk;

  shader_dispatch_ctrl #(
    .PROG_DEPTH(PROG_DEPTH),
    .UNIF_DEPTH(UNIF_DEPTH),
    .RES_DEPTH(RES_DEPTH),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_prog_we(cfg_prog_we),
    .cfg_prog_addr(cfg_prog_addr),
    .cfg_prog_wdata(cfg_prog_wdata),
    .cfg_unif_we(cfg_unif_we),
    .cfg_unif_idx(cfg_unif_idx),
    .cfg_unif_addr(cfg_unif_addr),
    .cfg_unif_data(cfg_unif_data),
    .start(start),
    .prog_len(prog_len),
    .unif_cnt(unif_cnt),
    .exp_out_cnt(exp_out_cnt),
    .busy(busy),
    .done(done),
    .err(err),
    .sp_uniform_valid(sp_uniform_valid),
    .sp_uniform_addr(sp_uniform_addr),
    .sp_uniform_data(sp_uniform_data),
    .sp_uniform_ready(sp_uniform_ready),
    .sp_instr_valid(sp_instr_valid),
    .sp_instr(sp_instr),
    .sp_instr_ready(sp_instr_ready),
    .sp_out_valid(sp_out_valid),
    .sp_out_data(sp_out_data),
    .sp_out_ready(sp_out_ready),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready),
    .res_count(res_count)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]  prog_model  [PROG_DEPTH];
  logic [31:0]  uaddr_model [UNIF_DEPTH];
  logic [127:0] udata_model [UNIF_DEPTH];

  logic [31:0]  exp_uaddr_q [$];
  logic [127:0] exp_udata_q [$];
  logic [31:0]  exp_instr_q [$];
  logic [127:0] exp_res_q   [$];

  bit rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got an unexpected event, expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake seen on an output stream is checked against the queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sp_uniform_valid || sp_instr_valid)
        checkOutput("single_valid", 128'(sp_uniform_valid && sp_instr_valid), 128'(0));
      if (sp_uniform_valid && sp_uniform_ready) begin
        if (exp_uaddr_q.size() == 0) failNow("unif_beat_unexpected");
        else begin
          checkOutput("unif_addr", 128'(sp_uniform_addr), 128'(exp_uaddr_q.pop_front()));
          checkOutput("unif_data", sp_uniform_data, exp_udata_q.pop_front());
        end
      end
      if (sp_instr_valid && sp_instr_ready) begin
        if (exp_instr_q.size() == 0) failNow("instr_beat_unexpected");
        else checkOutput("instr_word", 128'(sp_instr), 128'(exp_instr_q.pop_front()));
      end
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) failNow("res_pop_unexpected");
        else checkOutput("res_data", res_data, exp_res_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) begin
      sp_instr_ready   = 1'($urandom_range(0, 1));
      sp_uniform_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic loadProg(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_prog_we    = 1'b1;
      cfg_prog_addr  = 8'(i);
      cfg_prog_wdata = $urandom;
      prog_model[i]  = cfg_prog_wdata;
      tick();
    end
    cfg_prog_we = 1'b0;
  endtask

  task automatic loadUnif(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_unif_we    = 1'b1;
      cfg_unif_idx   = 4'(i);
      cfg_unif_addr  = $urandom;
      cfg_unif_data  = {$urandom, $urandom, $urandom, $urandom};
      uaddr_model[i] = cfg_unif_addr;
      udata_model[i] = cfg_unif_data;
      tick();
    end
    cfg_unif_we = 1'b0;
  endtask

  // Queues the beats a well-formed job must emit, then pulses start for one cycle.
  task automatic applyStimulus(input int plen, input int ucnt, input int ecnt);
    if (plen <= PROG_DEPTH && ucnt <= UNIF_DEPTH) begin
      for (int i = 0; i < ucnt; i++) begin
        exp_uaddr_q.push_back(uaddr_model[i]);
        exp_udata_q.push_back(udata_model[i]);
      end
      for (int i = 0; i < plen; i++) exp_instr_q.push_back(prog_model[i]);
    end
    prog_len    = 9'(plen);
    unif_cnt    = 5'(ucnt);
    exp_out_cnt = 16'(ecnt);
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendResult(input logic [127:0] data, input bit keep);
    bit ok = 1'b0;
    sp_out_valid = 1'b1;
    sp_out_data  = data;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sp_out_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && keep) exp_res_q.push_back(data);
    tick();
    sp_out_valid = 1'b0;
    if (!ok) failNow("result_accept_timeout");
  endtask

  task automatic waitDone(input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 128'(got), 128'(1));
    tick();
  endtask

  task automatic drainResults(input int budget);
    res_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!res_valid) break;
      tick();
    end
    tick();
    res_ready = 1'b0;
    checkOutput("res_all_popped", 128'(exp_res_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n_done;
    int plen;
    int ucnt;
    rst_n = 1'b0;
    cfg_prog_we = 1'b0; cfg_prog_addr = '0; cfg_prog_wdata = '0;
    cfg_unif_we = 1'b0; cfg_unif_idx = '0; cfg_unif_addr = '0; cfg_unif_data = '0;
    start = 1'b0; prog_len = '0; unif_cnt = '0; exp_out_cnt = '0;
    sp_uniform_ready = 1'b1; sp_instr_ready = 1'b1;
    sp_out_valid = 1'b0; sp_out_data = '0; res_ready = 1'b0;

    tick(); tick();
    @(negedge clk);
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    checkOutput("rst_uvalid", 128'(sp_uniform_valid), 128'(0));
    checkOutput("rst_ivalid", 128'(sp_instr_valid), 128'(0));
    checkOutput("rst_res_valid", 128'(res_valid), 128'(0));
    checkOutput("rst_res_count", 128'(res_count), 128'(0));
    checkOutput("rst_out_ready", 128'(sp_out_ready), 128'(1));
    checkOutput("rst_instr", 128'(sp_instr), 128'(0));
    checkOutput("rst_uaddr", 128'(sp_uniform_addr), 128'(0));
    checkOutput("rst_udata", sp_uniform_data, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] basic job: 3 uniforms, 4 instructions, 2 results");
    loadUnif(3);
    loadProg(4);
    applyStimulus(4, 3, 2);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("start_busy", 128'(busy), 128'(1));
      checkOutput("burst_uvalid", 128'(sp_uniform_valid), 128'(k < 3));
      checkOutput("burst_ivalid", 128'(sp_instr_valid), 128'(k >= 3));
      tick();
    end
    sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    waitDone(50);
    @(negedge clk);
    checkOutput("basic_res_count", 128'(res_count), 128'(2));
    checkOutput("basic_busy_after", 128'(busy), 128'(0));
    checkOutput("basic_err", 128'(err), 128'(0));
    tick();
    drainResults(20);

    $display("[TB] random backpressure jobs");
    for (int it = 0; it < 2; it++) begin
      ucnt = $urandom_range(1, 5);
      plen = $urandom_range(16, 40);
      loadUnif(ucnt);
      loadProg(plen);
      applyStimulus(plen, ucnt, 3);
      rand_ready = 1'b1;
      for (int r = 0; r < 3; r++) sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      waitDone(2000);
      rand_ready = 1'b0;
      sp_instr_ready = 1'b1;
      sp_uniform_ready = 1'b1;
      checkOutput("bp_unif_all_sent", 128'(exp_uaddr_q.size()), 128'(0));
      checkOutput("bp_instr_all_sent", 128'(exp_instr_q.size()), 128'(0));
      drainResults(20);
    end

    $display("[TB] result FIFO full");
    loadProg(1);
    applyStimulus(1, 0, 9);
    for (int r = 0; r < 8; r++) sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    @(negedge clk);
    checkOutput("full_out_ready", 128'(sp_out_ready), 128'(0));
    checkOutput("full_count", 128'(res_count), 128'(8));
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    waitDone(50);
    @(negedge clk);
    checkOutput("full_count_after", 128'(res_count), 128'(8));
    tick();
    drainResults(30);

    $display("[TB] empty job");
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("empty_done", 128'(done), 128'(1));
    checkOutput("empty_busy", 128'(busy), 128'(1));
    tick();
    @(negedge clk);
    checkOutput("empty_done_gone", 128'(done), 128'(0));
    checkOutput("empty_busy_gone", 128'(busy), 128'(0));
    tick();

    $display("[TB] oversize lengths");
    applyStimulus(300, 0, 0);
    @(negedge clk);
    checkOutput("badlen_done", 128'(done), 128'(1));
    checkOutput("badlen_err", 128'(err), 128'(1));
    tick(); tick();
    applyStimulus(0, 17, 0);
    @(negedge clk);
    checkOutput("badunif_err", 128'(err), 128'(1));
    tick(); tick();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("start_clears_err", 128'(err), 128'(0));
    tick(); tick();

    $display("[TB] stray result in idle");
    sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(negedge clk);
    checkOutput("stray_err", 128'(err), 128'(1));
    checkOutput("stray_count", 128'(res_count), 128'(0));
    tick();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("stray_err_cleared", 128'(err), 128'(0));
    tick(); tick();

    $display("[TB] start while busy");
    loadProg(20);
    sp_instr_ready = 1'b0;
    applyStimulus(20, 0, 0);
    tick(); tick(); tick();
    prog_len = 9'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    sp_instr_ready = 1'b1;
    waitDone(200);
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) n_done++;
      tick();
    end
    checkOutput("busy_start_no_extra_done", 128'(n_done), 128'(0));
    checkOutput("busy_start_instr_sent", 128'(exp_instr_q.size()), 128'(0));

    $display("[TB] reset during instruction phase");
    loadProg(30);
    applyStimulus(30, 0, 0);
    sendResult({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    exp_instr_q.delete();
    exp_res_q.delete();
    @(negedge clk);
    checkOutput("rstmid_ivalid", 128'(sp_instr_valid), 128'(0));
    checkOutput("rstmid_uvalid", 128'(sp_uniform_valid), 128'(0));
    checkOutput("rstmid_busy", 128'(busy), 128'(0));
    checkOutput("rstmid_count", 128'(res_count), 128'(0));
    checkOutput("rstmid_done", 128'(done), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("post_reset_done", 128'(done), 128'(1));
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
